hilo_md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide controller that owns the HI/LO register pair in the E stage.

---
 rtl/hilo_md_sequencer_pkg.sv | 25 ++
 rtl/hilo_md_sequencer_alu.sv | 67 ++++++
 rtl/hilo_md_sequencer.sv | 124 ++++++++++++
 tb/tb_hilo_md_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_md_sequencer_pkg.sv
// hilo_md_sequencer_pkg
//  Shared definitions for the HI/LO multiply/divide sequencer:
//   - md op codes driven by the E stage on md_op
//   - default busy-window lengths for multiply and divide
//   - FSM state encoding of the sequencer
package hilo_md_sequencer_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

endpackage

// File: rtl/hilo_md_sequencer_alu.sv
// hilo_md_alu
//  Combinational 64-bit multiply/divide result for the HI/LO pair.
//  Ports:
//   op_i       md op code of the latched operation
//   a_i, b_i   latched rs / rt operands
//   hi_i, lo_i current architectural HI/LO (returned unchanged when no result)
//   hi_o, lo_o value HI/LO take at commit
module hilo_md_alu
   import hilo_md_sequencer_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;

   always_comb begin
      hi_o  = hi_i;
      lo_o  = lo_i;
      prod  = 64'd0;
      q_mag = 32'd0;
      r_mag = 32'd0;
      // Signed divide works on magnitudes so that 0x80000000 / -1 simply
      // wraps back to 0x80000000 instead of hitting a signed overflow.
      a_mag = a_i[31] ? (~a_i + 32'd1) : a_i;
      b_mag = b_i[31] ? (~b_i + 32'd1) : b_i;
      case (op_i)
         MD_MULT: begin
            prod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
            hi_o = prod[63:32];
            lo_o = prod[31:0];
         end
         MD_MULTU: begin
            prod = {32'd0, a_i} * {32'd0, b_i};
            hi_o = prod[63:32];
            lo_o = prod[31:0];
         end
         MD_DIV: begin
            // Zero divisor leaves HI/LO untouched.
            if (b_i != 32'd0) begin
               q_mag = a_mag / b_mag;
               r_mag = a_mag % b_mag;
               lo_o  = (a_i[31] ^ b_i[31]) ? (~q_mag + 32'd1) : q_mag;
               hi_o  = a_i[31] ? (~r_mag + 32'd1) : r_mag;
            end
         end
         MD_DIVU: begin
            if (b_i != 32'd0) begin
               lo_o = a_i / b_i;
               hi_o = a_i % b_i;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/hilo_md_sequencer.sv
// hilo_md_sequencer
//  E-stage owner of HI/LO. Accepts one md/mt op per start pulse, runs a
//  fixed-length busy window for mult/div and commits the result at its end.
//  Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   start      valid md/mt op in E this cycle
//   md_op      op code, sampled only with start
//   rs_val     forwarded rs operand
//   rt_val     forwarded rt operand
//   hilo_busy  operation in flight (registered)
//   hi, lo     architectural HI/LO
module hilo_md_sequencer
   import hilo_md_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        hilo_busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             busy_q;
   logic [31:0]      alu_hi;
   logic [31:0]      alu_lo;

   hilo_md_alu u_alu (
      .op_i (op_q),
      .a_i  (a_q),
      .b_i  (b_q),
      .hi_i (hi_q),
      .lo_i (lo_q),
      .hi_o (alu_hi),
      .lo_o (alu_lo)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (md_op)
                  MD_MULT, MD_MULTU: begin
                     a_d     = rs_val;
                     b_d     = rt_val;
                     op_d    = md_op;
                     count_d = CNT_W'(MULT_CYCLES);
                     state_d = ST_MUL;
                  end
                  MD_DIV, MD_DIVU: begin
                     a_d     = rs_val;
                     b_d     = rt_val;
                     op_d    = md_op;
                     count_d = CNT_W'(DIV_CYCLES);
                     state_d = ST_DIV;
                  end
                  MD_MTHI: hi_d = rs_val;
                  MD_MTLO: lo_d = rs_val;
                  default: begin
                  end
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            // start is ignored here; upstream stall keeps it low.
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               hi_d    = alu_hi;
               lo_d    = alu_lo;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= MD_NONE;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign hilo_busy = busy_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_md_sequencer.sv
module tb_hilo_md_sequencer;
   import hilo_md_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        hilo_busy;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   hilo_md_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .hilo_busy (hilo_busy),
      .hi        (hi),
      .lo        (lo)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   int          overlap_seen = 0;
   logic        mt_flag = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output exp_t e, output bit push);
      longint          sa, sbv, q, r;
      longint unsigned ua, ub, p;
      logic [63:0]     v;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      e.hi = m_hi; e.lo = m_lo; e.cycles = 0; e.name = "none";
      push = 1'b1;
      case (op)
         MD_MULT:  begin v = sa * sbv; e.hi = v[63:32]; e.lo = v[31:0]; e.cycles = 5; e.name = "mult"; end
         MD_MULTU: begin p = ua * ub;  v = p; e.hi = v[63:32]; e.lo = v[31:0]; e.cycles = 5; e.name = "multu"; end
         MD_DIV: begin
            e.cycles = 10; e.name = "div";
            if (b != 0) begin
               q = sa / sbv; r = sa % sbv;
               v = q; e.lo = v[31:0];
               v = r; e.hi = v[31:0];
            end
         end
         MD_DIVU: begin
            e.cycles = 10; e.name = "divu";
            if (b != 0) begin
               p = ua / ub; v = p; e.lo = v[31:0];
               p = ua % ub; v = p; e.hi = v[31:0];
            end
         end
         MD_MTHI: begin e.hi = a; e.name = "mthi"; end
         MD_MTLO: begin e.lo = a; e.name = "mtlo"; end
         default: push = 1'b0;
      endcase
   endtask

   // Drives one start pulse at the current negedge; returns at the next one.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit   push;
      model(op, a, b, e, push);
      if (push) begin
         sb.push_back(e);
         m_hi = e.hi;
         m_lo = e.lo;
      end
      $display("issue op=%0d rs=%08h rt=%08h -> hi=%08h lo=%08h", op, a, b, e.hi, e.lo);
      start  = 1'b1;
      md_op  = op;
      rs_val = a;
      rt_val = b;
      @(negedge clk);
      start  = 1'b0;
      rs_val = $urandom;
      rt_val = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (hilo_busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (hilo_busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle busy still high after %0d cycles", n);
      end
      @(negedge clk);
   endtask

   task automatic pop_check(input int measured);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL commit unexpected hi=%08h lo=%08h", hi, lo);
      end else begin
         e = sb.pop_front();
         check32({e.name, "_hi"}, hi, e.hi);
         check32({e.name, "_lo"}, lo, e.lo);
         check32({e.name, "_busy_cycles"}, measured, e.cycles);
         $display("commit %s hi=%08h lo=%08h busy=%0d", e.name, hi, lo, measured);
      end
   endtask

   // Accepted-mt detection and overlap (start while busy) detection.
   always @(posedge clk) begin
      mt_flag <= reset && start && !hilo_busy && (md_op == MD_MTHI || md_op == MD_MTLO);
      if (reset && start && hilo_busy) begin
         overlap_seen <= overlap_seen + 1;
         $display("note: start while busy, op=%0d", md_op);
      end
   end

   // Monitor: a busy window closing, or an accepted mt, presents a result.
   initial begin : monitor
      int busy_cnt = 0;
      bit prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
         end else begin
            if (hilo_busy) busy_cnt++;
            if (prev_busy && !hilo_busy) begin
               pop_check(busy_cnt);
               busy_cnt = 0;
            end
            if (mt_flag) pop_check(hilo_busy ? 1 : 0);
            prev_busy = hilo_busy;
         end
      end
   end

   initial begin : stim
      logic [2:0]  op;
      logic [31:0] a, b;

      #1;
      check32("reset_busy", {31'd0, hilo_busy}, 32'd0);
      check32("reset_hi", hi, 32'd0);
      check32("reset_lo", lo, 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);

      // Reset during MUL with count=3 aborts and clears everything.
      issue(MD_MTHI, 32'h1111_2222, 32'd0);
      issue(MD_MTLO, 32'h3333_4444, 32'd0);
      issue(MD_MULT, 32'h0000_1234, 32'h0000_5678);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check32("abort_busy", {31'd0, hilo_busy}, 32'd0);
      check32("abort_hi", hi, 32'd0);
      check32("abort_lo", lo, 32'd0);
      sb.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      #2 reset = 1'b1;
      repeat (12) @(negedge clk);
      check32("no_late_commit_hi", hi, 32'd0);
      check32("no_late_commit_lo", lo, 32'd0);
      check32("no_late_commit_busy", {31'd0, hilo_busy}, 32'd0);

      // Directed arithmetic cases.
      issue(MD_MULT,  32'hFFFF_FFFE, 32'd3);          wait_idle();
      issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);          wait_idle();
      issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);          wait_idle();
      issue(MD_DIVU,  32'd7,         32'd2);          wait_idle();
      issue(MD_MTHI,  32'h0000_1234, 32'd0);
      issue(MD_MTLO,  32'h0000_1234, 32'd0);
      issue(MD_DIV,   32'h0BAD_F00D, 32'd0);          wait_idle();
      issue(MD_DIVU,  32'h0BAD_F00D, 32'd0);          wait_idle();
      issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);  wait_idle();
      issue(MD_MTHI,  32'h0000_ABCD, 32'd0);
      issue(MD_MTLO,  32'h0000_0055, 32'd0);
      @(negedge clk);

      // start MULT while DIV busy (count=6) must be ignored.
      issue(MD_DIV, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      start  = 1'b1;
      md_op  = MD_MULT;
      rs_val = 32'h7FFF_FFFF;
      rt_val = 32'h7FFF_FFFF;
      @(negedge clk);
      start  = 1'b0;
      wait_idle();

      // Randomized ops with some zero divisors and corner operands.
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 9)) ^ {32{a[0]}};
            default: begin end
         endcase
         issue(op, a, b);
         wait_idle();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check32("overlap_detected", overlap_seen, 32'd1);
      check32("scoreboard_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule
